// File: rtl/p1_instr_decoder.sv
// p1_instr_decoder: RV32I instruction decoder with a 32x32 register-file read
// stage. One cycle of latency; every output comes straight from a register.
// Illegal encodings raise hata and zero everything except opcode.
// Optional feature macro: P1_WRITEBACK_EN adds a single write port
// (wb_en/wb_addr/wb_data) with same-edge read bypass. Without it the
// register file holds x[i] = i from reset onward.
module p1_instr_decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] komut,
`ifdef P1_WRITEBACK_EN
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
`endif
    output logic [6:0]  opcode,
    output logic [3:0]  aluop,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic        hata
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [31:0] r_regs [32];

    logic [6:0]  r_opcode;
    logic [3:0]  r_aluop;
    logic [4:0]  r_rs1, r_rs2, r_rd;
    logic [31:0] r_rs1_data, r_rs2_data, r_imm;
    logic        r_hata;

    logic [6:0]  w_op, w_f7;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [3:0]  w_aluop;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [31:0] w_imm, w_rs1_data, w_rs2_data;
    logic        w_hata;

    assign w_op = komut[6:0];
    assign w_f3 = komut[14:12];
    assign w_f7 = komut[31:25];

    assign w_imm_i = {{20{komut[31]}}, komut[31:20]};
    assign w_imm_s = {{20{komut[31]}}, komut[31:25], komut[11:7]};
    assign w_imm_b = {{19{komut[31]}}, komut[31], komut[7], komut[30:25], komut[11:8], 1'b0};
    assign w_imm_u = {komut[31:12], 12'b0};
    assign w_imm_j = {{11{komut[31]}}, komut[31], komut[19:12], komut[20], komut[30:21], 1'b0};

    // Decode fields per format; fields stay zero unless the encoding is legal.
    always_comb begin
        w_aluop = 4'b0000;
        w_rs1   = 5'd0;
        w_rs2   = 5'd0;
        w_rd    = 5'd0;
        w_imm   = 32'd0;
        w_hata  = 1'b0;
        if (komut[1:0] != 2'b11) begin
            w_hata = 1'b1;
        end else begin
            case (w_op)
                OP_R: begin
                    if (w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
                        w_rs1   = komut[19:15];
                        w_rs2   = komut[24:20];
                        w_rd    = komut[11:7];
                        w_aluop = {w_f7[5], w_f3};
                    end else begin
                        w_hata = 1'b1;
                    end
                end
                OP_IMM: begin
                    if ((w_f3 == 3'b001 && w_f7 != 7'h00) ||
                        (w_f3 == 3'b101 && w_f7 != 7'h00 && w_f7 != 7'h20)) begin
                        w_hata = 1'b1;
                    end else begin
                        w_rs1   = komut[19:15];
                        w_rd    = komut[11:7];
                        w_imm   = w_imm_i;
                        w_aluop = {(w_f3 == 3'b101) ? w_f7[5] : 1'b0, w_f3};
                    end
                end
                OP_LOAD: begin
                    if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111) begin
                        w_hata = 1'b1;
                    end else begin
                        w_rs1 = komut[19:15];
                        w_rd  = komut[11:7];
                        w_imm = w_imm_i;
                    end
                end
                OP_STORE: begin
                    if (w_f3 > 3'b010) begin
                        w_hata = 1'b1;
                    end else begin
                        w_rs1 = komut[19:15];
                        w_rs2 = komut[24:20];
                        w_imm = w_imm_s;
                    end
                end
                OP_BRANCH: begin
                    if (w_f3 == 3'b010 || w_f3 == 3'b011) begin
                        w_hata = 1'b1;
                    end else begin
                        w_rs1 = komut[19:15];
                        w_rs2 = komut[24:20];
                        w_imm = w_imm_b;
                        // BEQ/BNE subtract, BLT/BGE signed compare, BLTU/BGEU unsigned
                        case (w_f3[2:1])
                            2'b00:   w_aluop = 4'b1000;
                            2'b10:   w_aluop = 4'b0010;
                            default: w_aluop = 4'b0011;
                        endcase
                    end
                end
                OP_JAL: begin
                    w_rd  = komut[11:7];
                    w_imm = w_imm_j;
                end
                OP_JALR: begin
                    if (w_f3 != 3'b000) begin
                        w_hata = 1'b1;
                    end else begin
                        w_rs1 = komut[19:15];
                        w_rd  = komut[11:7];
                        w_imm = w_imm_i;
                    end
                end
                OP_LUI: begin
                    w_rd    = komut[11:7];
                    w_imm   = w_imm_u;
                    w_aluop = 4'b1111;
                end
                OP_AUIPC: begin
                    w_rd  = komut[11:7];
                    w_imm = w_imm_u;
                end
                OP_FENCE, OP_SYSTEM: begin
                    // treated as NOPs: every field stays zero
                end
                default: w_hata = 1'b1;
            endcase
        end
    end

    // Register-file read of the emitted indices; x0 is hard-wired to zero.
    always_comb begin
        w_rs1_data = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
        w_rs2_data = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];
`ifdef P1_WRITEBACK_EN
        // a write landing on the same edge is forwarded to the reader
        if (wb_en && wb_addr != 5'd0 && wb_addr == w_rs1) w_rs1_data = wb_data;
        if (wb_en && wb_addr != 5'd0 && wb_addr == w_rs2) w_rs2_data = wb_data;
`endif
    end

    // Output registers and register file; reset clears outputs and seeds x[i] = i.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_opcode   <= 7'd0;
            r_aluop    <= 4'd0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_rd       <= 5'd0;
            r_imm      <= 32'd0;
            r_rs1_data <= 32'd0;
            r_rs2_data <= 32'd0;
            r_hata     <= 1'b0;
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'(i);
        end else begin
            r_opcode   <= w_op;
            r_aluop    <= w_aluop;
            r_rs1      <= w_rs1;
            r_rs2      <= w_rs2;
            r_rd       <= w_rd;
            r_imm      <= w_imm;
            r_rs1_data <= w_rs1_data;
            r_rs2_data <= w_rs2_data;
            r_hata     <= w_hata;
`ifdef P1_WRITEBACK_EN
            if (wb_en && wb_addr != 5'd0) r_regs[wb_addr] <= wb_data;
`endif
        end
    end

    assign opcode   = r_opcode;
    assign aluop    = r_aluop;
    assign rs1      = r_rs1;
    assign rs2      = r_rs2;
    assign rd       = r_rd;
    assign imm      = r_imm;
    assign rs1_data = r_rs1_data;
    assign rs2_data = r_rs2_data;
    assign hata     = r_hata;

endmodule

// File: tb/tb_p1_instr_decoder.sv
// Testbench for p1_instr_decoder: scenario tasks drive instruction words,
// push expected output bundles into a scoreboard queue and compare one
// cycle later when the registered outputs appear.
module tb_p1_instr_decoder;

    typedef struct packed {
        logic [6:0]  op;
        logic [3:0]  alu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        hata;
    } out_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] komut = 32'd0;
`ifdef P1_WRITEBACK_EN
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = 5'd0;
    logic [31:0] wb_data = 32'd0;
`endif
    logic [6:0]  opcode;
    logic [3:0]  aluop;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_data, rs2_data, imm;
    logic        hata;

    out_t got;
    out_t sb[$];
    int   n_checks = 0;
    int   n_err = 0;

    assign got = {opcode, aluop, rs1, rs2, rs1_data, rs2_data, rd, imm, hata};

    p1_instr_decoder dut (
        .clk      (clk),
        .reset    (reset),
        .komut    (komut),
`ifdef P1_WRITEBACK_EN
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
`endif
        .opcode   (opcode),
        .aluop    (aluop),
        .rs1      (rs1),
        .rs2      (rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd       (rd),
        .imm      (imm),
        .hata     (hata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout n_checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    // Expected bundle; after reset the register file holds x[i] = i.
    function automatic out_t mk(input logic [6:0] op, input logic [3:0] alu,
                                input logic [4:0] r1, input logic [4:0] r2,
                                input logic [4:0] d, input logic [31:0] im,
                                input logic h);
        out_t e;
        e.op = op; e.alu = alu; e.rs1 = r1; e.rs2 = r2;
        e.d1 = {27'd0, r1}; e.d2 = {27'd0, r2};
        e.rd = d; e.imm = im; e.hata = h;
        return e;
    endfunction

    task automatic test_reset();
        out_t e;
        komut = 32'h002081B3;
        @(negedge clk); reset = 1'b1;
        sb.push_back('0);
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks++;
        if (got !== e) begin
            n_err++;
            $display("FAIL reset got=%h exp=%h", got, e);
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_illegal();
        logic [31:0] k [6];
        out_t e;
        k[0] = 32'h00000001;   // low bits not 11
        k[1] = 32'h402091B3;   // R-type f7=0x20 with f3=001
        k[2] = 32'h40331293;   // SLLI with f7!=0
        k[3] = 32'h00009067;   // JALR f3=001
        k[4] = 32'h0000B003;   // LOAD f3=011
        k[5] = 32'h00002063;   // BRANCH f3=010
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); komut = k[i];
            sb.push_back(mk(k[i][6:0], 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1));
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_err++;
                $display("FAIL illegal[%0d] komut=%h got=%h exp=%h", i, k[i], got, e);
            end
        end
    endtask

    task automatic test_alu();
        logic [31:0] k [4];
        out_t x [4];
        out_t e;
        k[0] = 32'h002081B3; x[0] = mk(7'h33, 4'b0000, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);           // add x3,x1,x2
        k[1] = 32'h402081B3; x[1] = mk(7'h33, 4'b1000, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);           // sub x3,x1,x2
        k[2] = 32'hFFF00293; x[2] = mk(7'h13, 4'b0000, 5'd0, 5'd0, 5'd5, 32'hFFFFFFFF, 1'b0);    // addi x5,x0,-1
        k[3] = 32'h40335293; x[3] = mk(7'h13, 4'b1101, 5'd6, 5'd0, 5'd5, 32'h00000403, 1'b0);    // srai x5,x6,3
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); komut = k[i];
            sb.push_back(x[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_err++;
                $display("FAIL alu[%0d] komut=%h got=%h exp=%h", i, k[i], got, e);
            end
        end
    endtask

    task automatic test_mem_ctrl();
        logic [31:0] k [7];
        out_t x [7];
        out_t e;
        k[0] = 32'h0020A423; x[0] = mk(7'h23, 4'b0000, 5'd1, 5'd2, 5'd0, 32'd8, 1'b0);           // sw x2,8(x1)
        k[1] = 32'hFFFFA203; x[1] = mk(7'h03, 4'b0000, 5'd31, 5'd0, 5'd4, 32'hFFFFFFFF, 1'b0);   // lw x4,-1(x31)
        k[2] = 32'hFE208EE3; x[2] = mk(7'h63, 4'b1000, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 1'b0);    // beq x1,x2,-4
        k[3] = 32'h0062E063; x[3] = mk(7'h63, 4'b0011, 5'd5, 5'd6, 5'd0, 32'd0, 1'b0);           // bltu x5,x6,0
        k[4] = 32'h008000EF; x[4] = mk(7'h6F, 4'b0000, 5'd0, 5'd0, 5'd1, 32'd8, 1'b0);           // jal x1,+8
        k[5] = 32'h123453B7; x[5] = mk(7'h37, 4'b1111, 5'd0, 5'd0, 5'd7, 32'h12345000, 1'b0);    // lui x7,0x12345
        k[6] = 32'hFFFFF097; x[6] = mk(7'h17, 4'b0000, 5'd0, 5'd0, 5'd1, 32'hFFFFF000, 1'b0);    // auipc x1,0xFFFFF
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); komut = k[i];
            sb.push_back(x[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_err++;
                $display("FAIL memctrl[%0d] komut=%h got=%h exp=%h", i, k[i], got, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] k [5];
        logic        r [5];
        out_t x [5];
        out_t e;
        k[0] = 32'h0FF0000F; r[0] = 1'b0; x[0] = mk(7'h0F, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);          // fence
        k[1] = 32'h00000073; r[1] = 1'b0; x[1] = mk(7'h73, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);          // ecall
        k[2] = 32'hFE208EE3; r[2] = 1'b0; x[2] = mk(7'h63, 4'b1000, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 1'b0);
        k[3] = 32'hFE208EE3; r[3] = 1'b1; x[3] = '0;                                                     // reset mid-stream wins
        k[4] = 32'h002081B3; r[4] = 1'b0; x[4] = mk(7'h33, 4'b0000, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); komut = k[i]; reset = r[i];
            sb.push_back(x[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_err++;
                $display("FAIL b2b[%0d] komut=%h rst=%0b got=%h exp=%h", i, k[i], r[i], got, e);
            end
        end
        @(negedge clk); reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        test_reset();
        test_illegal();
        test_alu();
        test_mem_ctrl();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
